// File: rtl/pkt_tx_mux_pkg.sv
// rtl/pkt_tx_mux_pkg.sv - shared FSM state type, width helpers and counter width for pkt_tx_mux
package pkt_tx_mux_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    // Width of each per-channel transmitted-packet counter
    localparam int CNT_W = 32;

    // Bits needed to express a byte count within one data word
    function automatic int mod_width(input int data_w);
        return $clog2(data_w / 8);
    endfunction

    // Channel index width, never narrower than one bit
    function automatic int ch_width(input int num_ch);
        return (num_ch > 2) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/pkt_tx_mux_rr_arbiter.sv
// rtl/pkt_tx_mux_rr_arbiter.sv - combinational round-robin arbiter for pkt_tx_mux
// Ports:
//   req     in  NUM_CH  request vector
//   ptr     in  CH_W    highest-priority channel this round
//   gnt     out NUM_CH  one-hot grant
//   gnt_val out 1       any request granted
module rr_arbiter
    import pkt_tx_mux_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CH_W   = ch_width(NUM_CH)
)
(
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    output logic [NUM_CH-1:0] gnt,
    output logic              gnt_val
);

    logic [CH_W-1:0] idx;

    // Scan from ptr upwards with wrap; the first requester found wins
    always_comb begin
        gnt     = '0;
        gnt_val = 1'b0;
        idx     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = CH_W'((int'(ptr) + i) % NUM_CH);
            if (!gnt_val && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_val  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pkt_tx_mux.sv
// rtl/pkt_tx_mux.sv - packet-atomic round-robin mux of NUM_CH packet sources onto one MAC transmit port
// Optional feature: define PKT_TX_MUX_STATS_EN for per-channel transmitted-packet counters.
// Ports:
//   clk_156m25, reset_156m25           clock, synchronous active-high reset
//   in_val/in_sop/in_eop [NUM_CH]      per-channel word qualifiers
//   in_mod [NUM_CH*MOD_W]              per-channel byte count on eop word (0 = all bytes)
//   in_data [NUM_CH*DATA_W]            per-channel data, channel k in slice k
//   in_ready [NUM_CH]                  per-channel accept
//   pkt_tx_data/val/sop/eop/mod        MAC transmit interface, registered
//   pkt_tx_full                        MAC backpressure
//   grant_ch                           channel currently owning the output
//   err_proto                          one-cycle protocol-error pulse
//   pkt_cnt [NUM_CH*32]                per-channel transmitted-packet counters
module pkt_tx_mux
    import pkt_tx_mux_pkg::*;
#(
    parameter  int NUM_CH = 4,
    parameter  int DATA_W = 64,
    localparam int MOD_W  = mod_width(DATA_W),
    localparam int CH_W   = ch_width(NUM_CH)
)
(
    input  logic                      clk_156m25,
    input  logic                      reset_156m25,
    input  logic [NUM_CH-1:0]         in_val,
    input  logic [NUM_CH-1:0]         in_sop,
    input  logic [NUM_CH-1:0]         in_eop,
    input  logic [NUM_CH*MOD_W-1:0]   in_mod,
    input  logic [NUM_CH*DATA_W-1:0]  in_data,
    output logic [NUM_CH-1:0]         in_ready,
    output logic [DATA_W-1:0]         pkt_tx_data,
    output logic                      pkt_tx_val,
    output logic                      pkt_tx_sop,
    output logic                      pkt_tx_eop,
    output logic [MOD_W-1:0]          pkt_tx_mod,
    input  logic                      pkt_tx_full,
    output logic [CH_W-1:0]           grant_ch,
    output logic                      err_proto,
    output logic [NUM_CH*CNT_W-1:0]   pkt_cnt
);

    state_t              state_q;
    state_t              state_d;
    logic [CH_W-1:0]     rr_ptr_q;
    logic                first_q;     // next transfer in XFER is the packet's first word
    logic [NUM_CH-1:0]   req_elig;
    logic [NUM_CH-1:0]   stray;
    logic [NUM_CH-1:0]   arb_gnt;
    logic                arb_val;
    logic [CH_W-1:0]     win_idx;
    logic [CH_W-1:0]     rr_next;
    logic                xfer;
    logic                cur_val;
    logic                cur_sop;
    logic                cur_eop;
    logic [MOD_W-1:0]    cur_mod;
    logic [DATA_W-1:0]   cur_data;

    assign req_elig = in_val & in_sop;
    assign stray    = in_val & ~in_sop;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_rr_arbiter (
        .req     (req_elig),
        .ptr     (rr_ptr_q),
        .gnt     (arb_gnt),
        .gnt_val (arb_val)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (arb_gnt[i]) begin
                win_idx = CH_W'(i);
            end
        end
    end

    assign rr_next  = CH_W'((int'(win_idx) + 1) % NUM_CH);

    assign cur_val  = in_val[grant_ch];
    assign cur_sop  = in_sop[grant_ch];
    assign cur_eop  = in_eop[grant_ch];
    assign cur_mod  = in_mod[int'(grant_ch)*MOD_W +: MOD_W];
    assign cur_data = in_data[int'(grant_ch)*DATA_W +: DATA_W];

    always_ff @(posedge clk_156m25) begin
        if (reset_156m25) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Eligible channels are held off in IDLE so the first word moves only once
    // the grant is registered; stray non-sop words are accepted and dropped.
    always_comb begin
        state_d  = state_q;
        in_ready = '0;
        xfer     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = stray;
                if (arb_val) begin
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                in_ready[grant_ch] = !pkt_tx_full;
                xfer = cur_val && !pkt_tx_full;
                if (xfer && cur_eop) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (reset_156m25) begin
            in_ready = '0;
        end
    end

    always_ff @(posedge clk_156m25) begin
        if (reset_156m25) begin
            rr_ptr_q    <= '0;
            grant_ch    <= '0;
            first_q     <= 1'b0;
            pkt_tx_data <= '0;
            pkt_tx_val  <= 1'b0;
            pkt_tx_sop  <= 1'b0;
            pkt_tx_eop  <= 1'b0;
            pkt_tx_mod  <= '0;
            err_proto   <= 1'b0;
        end else begin
            if (state_q == ST_IDLE && arb_val) begin
                grant_ch <= win_idx;
                rr_ptr_q <= rr_next;
                first_q  <= 1'b1;
            end else if (xfer) begin
                first_q  <= 1'b0;
            end
            pkt_tx_val <= xfer;
            // A repeated sop inside a packet is passed through as payload
            pkt_tx_sop <= xfer && cur_sop && first_q;
            pkt_tx_eop <= xfer && cur_eop;
            if (xfer) begin
                pkt_tx_data <= cur_data;
                pkt_tx_mod  <= cur_mod;
            end
            err_proto <= (xfer && cur_sop && !first_q) ||
                         (state_q == ST_IDLE && (|stray));
        end
    end

`ifdef PKT_TX_MUX_STATS_EN
    logic [NUM_CH-1:0][CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_156m25) begin
        if (reset_156m25) begin
            cnt_q <= '0;
        end else if (xfer && cur_eop) begin
            cnt_q[grant_ch] <= cnt_q[grant_ch] + CNT_W'(1);
        end
    end

    assign pkt_cnt = cnt_q;
`else
    assign pkt_cnt = '0;
`endif

endmodule

// File: tb/tb_pkt_tx_mux.sv
// tb/tb_pkt_tx_mux.sv - directed self-checking bench for pkt_tx_mux (NUM_CH=4, DATA_W=64)
module tb_pkt_tx_mux;

    logic         clk_156m25 = 1'b0;
    logic         reset_156m25;
    logic [3:0]   in_val, in_sop, in_eop, in_ready;
    logic [11:0]  in_mod;
    logic [255:0] in_data;
    logic [63:0]  pkt_tx_data;
    logic         pkt_tx_val, pkt_tx_sop, pkt_tx_eop;
    logic [2:0]   pkt_tx_mod;
    logic         pkt_tx_full;
    logic [1:0]   grant_ch;
    logic         err_proto;
    logic [127:0] pkt_cnt;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Per-channel source queues
    logic [63:0] q_data [4][32];
    logic        q_sop  [4][32];
    logic        q_eop  [4][32];
    logic [2:0]  q_mod  [4][32];
    int          q_len  [4];
    int          q_idx  [4];
    logic [3:0]  fire_n = 4'b0;

    // Output log: {grant, sop, eop, mod, data}
    logic [70:0] out_ent [64];
    int          out_cyc [64];
    int          out_n = 0;
    int          err_cyc [16];
    int          err_n = 0;
    logic [31:0] exp_cnt [4];

    pkt_tx_mux #(.NUM_CH(4), .DATA_W(64)) dut (
        .clk_156m25   (clk_156m25),
        .reset_156m25 (reset_156m25),
        .in_val       (in_val),
        .in_sop       (in_sop),
        .in_eop       (in_eop),
        .in_mod       (in_mod),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .pkt_tx_data  (pkt_tx_data),
        .pkt_tx_val   (pkt_tx_val),
        .pkt_tx_sop   (pkt_tx_sop),
        .pkt_tx_eop   (pkt_tx_eop),
        .pkt_tx_mod   (pkt_tx_mod),
        .pkt_tx_full  (pkt_tx_full),
        .grant_ch     (grant_ch),
        .err_proto    (err_proto),
        .pkt_cnt      (pkt_cnt)
    );

    always #5 clk_156m25 = ~clk_156m25;

    function automatic logic [63:0] mk_data(input int ch, input int tag, input int w);
        return {8'hC0, 8'(ch), 32'(tag), 16'(w)};
    endfunction

    function automatic logic [70:0] ent(input int g, input logic s, input logic e,
                                        input int m, input logic [63:0] d);
        return {2'(g), s, e, 3'(m), d};
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk_156m25);
        #3;
    endtask

    task automatic add_pkt(input int ch, input int n, input int lastmod, input int tag);
        for (int w = 0; w < n; w++) begin
            q_data[ch][q_len[ch]] = mk_data(ch, tag, w);
            q_sop[ch][q_len[ch]]  = (w == 0);
            q_eop[ch][q_len[ch]]  = (w == n - 1);
            q_mod[ch][q_len[ch]]  = (w == n - 1) ? 3'(lastmod) : 3'(w + 1);
            q_len[ch]++;
        end
    endtask

    task automatic add_stray(input int ch, input int tag);
        q_data[ch][q_len[ch]] = mk_data(ch, tag, 0);
        q_sop[ch][q_len[ch]]  = 1'b0;
        q_eop[ch][q_len[ch]]  = 1'b0;
        q_mod[ch][q_len[ch]]  = 3'd0;
        q_len[ch]++;
    endtask

    task automatic clear_queues();
        for (int c = 0; c < 4; c++) begin
            q_len[c] = 0;
            q_idx[c] = 0;
        end
    endtask

    task automatic clr_log();
        out_n = 0;
        err_n = 0;
    endtask

    always @(negedge clk_156m25) fire_n = in_val & in_ready;

    // Source driver: advance a channel's queue after each accepted word
    always @(posedge clk_156m25) begin
        #1;
        for (int c = 0; c < 4; c++) begin
            if (fire_n[c] && q_idx[c] < q_len[c]) q_idx[c]++;
            if (q_idx[c] < q_len[c]) begin
                in_val[c]          = 1'b1;
                in_sop[c]          = q_sop[c][q_idx[c]];
                in_eop[c]          = q_eop[c][q_idx[c]];
                in_mod[c*3 +: 3]   = q_mod[c][q_idx[c]];
                in_data[c*64 +: 64] = q_data[c][q_idx[c]];
            end else begin
                in_val[c] = 1'b0;
                in_sop[c] = 1'b0;
                in_eop[c] = 1'b0;
            end
        end
    end

    // Output monitor
    always @(posedge clk_156m25) begin
        #1;
        cyc++;
        if (pkt_tx_val === 1'b1) begin
            if (out_n < 64) begin
                out_ent[out_n] = {grant_ch, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod, pkt_tx_data};
                out_cyc[out_n] = cyc;
                out_n++;
            end
            if (pkt_tx_eop === 1'b1) exp_cnt[pkt_tx_data[49:48]]++;
        end
        if (err_proto === 1'b1 && err_n < 16) begin
            err_cyc[err_n] = cyc;
            err_n++;
        end
    end

    task automatic test_reset();
        reset_156m25 = 1'b1;
        wait_cyc(1);
        for (int c = 0; c < 4; c++) add_pkt(c, 1, 0, 1);
        wait_cyc(2);
        checks++; if (in_ready !== 4'b0) begin errors++; $display("FAIL reset_in_ready got=%b want=0000", in_ready); end
        checks++; if ({pkt_tx_val, pkt_tx_sop, pkt_tx_eop} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b want=000", {pkt_tx_val, pkt_tx_sop, pkt_tx_eop}); end
        checks++; if ({pkt_tx_data, pkt_tx_mod} !== 67'd0) begin errors++; $display("FAIL reset_data got=%h/%0d want=0", pkt_tx_data, pkt_tx_mod); end
        checks++; if ({grant_ch, err_proto} !== 3'b000) begin errors++; $display("FAIL reset_grant_err got=%0d/%b want=0/0", grant_ch, err_proto); end
        checks++; if (pkt_cnt !== 128'd0) begin errors++; $display("FAIL reset_pkt_cnt got=%h want=0", pkt_cnt); end
        clear_queues();
        for (int c = 0; c < 4; c++) exp_cnt[c] = 32'd0;
        wait_cyc(1);
        reset_156m25 = 1'b0;
        wait_cyc(2);
    endtask

    task automatic test_round_robin();
        int c0;
        int order [5] = '{0, 1, 2, 3, 0};
        int tag;
        clr_log();
        c0 = cyc;
        for (int c = 0; c < 4; c++) add_pkt(c, 2, 0, 10);
        add_pkt(0, 2, 0, 11);
        wait_cyc(22);
        checks++; if (out_n !== 10) begin errors++; $display("FAIL rr_count got=%0d want=10", out_n); end
        for (int p = 0; p < 5; p++) begin
            tag = (p == 4) ? 11 : 10;
            checks++; if (out_ent[2*p] !== ent(order[p], 1'b1, 1'b0, 1, mk_data(order[p], tag, 0)))
                begin errors++; $display("FAIL rr_first_word p=%0d got=%h want=%h", p, out_ent[2*p], ent(order[p], 1'b1, 1'b0, 1, mk_data(order[p], tag, 0))); end
            checks++; if (out_ent[2*p+1] !== ent(order[p], 1'b0, 1'b1, 0, mk_data(order[p], tag, 1)))
                begin errors++; $display("FAIL rr_last_word p=%0d got=%h want=%h", p, out_ent[2*p+1], ent(order[p], 1'b0, 1'b1, 0, mk_data(order[p], tag, 1))); end
            checks++; if (out_cyc[2*p] !== c0 + 3 + 3*p)
                begin errors++; $display("FAIL rr_gap p=%0d got=%0d want=%0d", p, out_cyc[2*p], c0 + 3 + 3*p); end
        end
    endtask

    task automatic test_single_pkt();
        int c0;
        clr_log();
        c0 = cyc;
        add_pkt(2, 3, 5, 20);
        wait_cyc(10);
        checks++; if (out_n !== 3) begin errors++; $display("FAIL single_count got=%0d want=3", out_n); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (out_ent[i] !== ent(2, i == 0, i == 2, (i == 2) ? 5 : i + 1, mk_data(2, 20, i)))
                begin errors++; $display("FAIL single_word i=%0d got=%h want=%h", i, out_ent[i], ent(2, i == 0, i == 2, (i == 2) ? 5 : i + 1, mk_data(2, 20, i))); end
            checks++; if (out_cyc[i] !== c0 + 3 + i)
                begin errors++; $display("FAIL single_latency i=%0d got=%0d want=%0d", i, out_cyc[i], c0 + 3 + i); end
        end
        checks++; if (err_n !== 0) begin errors++; $display("FAIL single_err got=%0d want=0", err_n); end
    endtask

    task automatic test_backpressure();
        int c0;
        int exp_c [6];
        logic [70:0] exp_e [6];
        clr_log();
        c0 = cyc;
        add_pkt(1, 4, 7, 30);
        wait_cyc(2);
        add_pkt(0, 1, 2, 31);
        add_pkt(3, 1, 4, 32);
        wait_cyc(2);
        pkt_tx_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++; if ({in_ready, grant_ch} !== {4'b0000, 2'd1})
                begin errors++; $display("FAIL bp_hold k=%0d ready=%b grant=%0d want=0000/1", k, in_ready, grant_ch); end
            if (k > 0) begin
                checks++; if (pkt_tx_val !== 1'b0) begin errors++; $display("FAIL bp_no_val k=%0d got=%b want=0", k, pkt_tx_val); end
            end
            wait_cyc(1);
        end
        checks++; if (pkt_tx_val !== 1'b0) begin errors++; $display("FAIL bp_no_val_last got=%b want=0", pkt_tx_val); end
        pkt_tx_full = 1'b0;
        wait_cyc(10);
        exp_e[0] = ent(1, 1'b1, 1'b0, 1, mk_data(1, 30, 0)); exp_c[0] = c0 + 3;
        exp_e[1] = ent(1, 1'b0, 1'b0, 2, mk_data(1, 30, 1)); exp_c[1] = c0 + 4;
        exp_e[2] = ent(1, 1'b0, 1'b0, 3, mk_data(1, 30, 2)); exp_c[2] = c0 + 10;
        exp_e[3] = ent(1, 1'b0, 1'b1, 7, mk_data(1, 30, 3)); exp_c[3] = c0 + 11;
        exp_e[4] = ent(3, 1'b1, 1'b1, 4, mk_data(3, 32, 0)); exp_c[4] = c0 + 13;
        exp_e[5] = ent(0, 1'b1, 1'b1, 2, mk_data(0, 31, 0)); exp_c[5] = c0 + 15;
        checks++; if (out_n !== 6) begin errors++; $display("FAIL bp_count got=%0d want=6", out_n); end
        for (int i = 0; i < 6; i++) begin
            checks++; if (out_ent[i] !== exp_e[i] || out_cyc[i] !== exp_c[i])
                begin errors++; $display("FAIL bp_word i=%0d got=%h@%0d want=%h@%0d", i, out_ent[i], out_cyc[i], exp_e[i], exp_c[i]); end
        end
    endtask

    task automatic test_mid_sop();
        int c0;
        int base;
        clr_log();
        c0 = cyc;
        base = q_len[0];
        add_pkt(0, 3, 6, 40);
        q_sop[0][base + 1] = 1'b1;
        wait_cyc(10);
        checks++; if (out_n !== 3) begin errors++; $display("FAIL midsop_count got=%0d want=3", out_n); end
        checks++; if (out_ent[1] !== ent(0, 1'b0, 1'b0, 2, mk_data(0, 40, 1)))
            begin errors++; $display("FAIL midsop_fwd got=%h want=%h", out_ent[1], ent(0, 1'b0, 1'b0, 2, mk_data(0, 40, 1))); end
        checks++; if (out_ent[0][68] !== 1'b1 || out_ent[2][67] !== 1'b1)
            begin errors++; $display("FAIL midsop_frame sop=%b eop=%b want=1/1", out_ent[0][68], out_ent[2][67]); end
        checks++; if (err_n !== 1 || err_cyc[0] !== c0 + 4)
            begin errors++; $display("FAIL midsop_err n=%0d at=%0d want=1@%0d", err_n, err_cyc[0], c0 + 4); end
    endtask

    task automatic test_stray();
        int c0;
        clr_log();
        c0 = cyc;
        add_stray(3, 50);
        wait_cyc(1);
        checks++; if (in_ready !== 4'b1000) begin errors++; $display("FAIL stray_ready got=%b want=1000", in_ready); end
        wait_cyc(6);
        checks++; if (err_n !== 1 || err_cyc[0] !== c0 + 2)
            begin errors++; $display("FAIL stray_err n=%0d at=%0d want=1@%0d", err_n, err_cyc[0], c0 + 2); end
        checks++; if (out_n !== 0) begin errors++; $display("FAIL stray_output got=%0d want=0", out_n); end
        checks++; if (q_idx[3] !== q_len[3]) begin errors++; $display("FAIL stray_dropped idx=%0d want=%0d", q_idx[3], q_len[3]); end
        clr_log();
        add_stray(1, 51);
        add_stray(2, 52);
        wait_cyc(1);
        checks++; if (in_ready !== 4'b0110) begin errors++; $display("FAIL stray2_ready got=%b want=0110", in_ready); end
        wait_cyc(6);
        checks++; if (err_n !== 1 || out_n !== 0)
            begin errors++; $display("FAIL stray2_single_pulse err=%0d out=%0d want=1/0", err_n, out_n); end
    endtask

    task automatic test_reset_mid();
        int c0;
        clr_log();
        c0 = cyc;
        add_pkt(1, 4, 3, 60);
        wait_cyc(3);
        reset_156m25 = 1'b1;
        clear_queues();
        for (int c = 0; c < 4; c++) exp_cnt[c] = 32'd0;
        wait_cyc(1);
        checks++; if ({pkt_tx_val, pkt_tx_sop, pkt_tx_eop, err_proto, grant_ch, in_ready} !== 10'd0)
            begin errors++; $display("FAIL rstmid_outputs got=%b want=0", {pkt_tx_val, pkt_tx_sop, pkt_tx_eop, err_proto, grant_ch, in_ready}); end
        checks++; if ({pkt_tx_data, pkt_tx_mod} !== 67'd0)
            begin errors++; $display("FAIL rstmid_data got=%h/%0d want=0", pkt_tx_data, pkt_tx_mod); end
        reset_156m25 = 1'b0;
        add_pkt(0, 2, 1, 61);
        wait_cyc(8);
        checks++; if (out_n !== 3) begin errors++; $display("FAIL rstmid_count got=%0d want=3", out_n); end
        checks++; if (out_ent[0] !== ent(1, 1'b1, 1'b0, 1, mk_data(1, 60, 0)))
            begin errors++; $display("FAIL rstmid_abandon got=%h want=%h", out_ent[0], ent(1, 1'b1, 1'b0, 1, mk_data(1, 60, 0))); end
        checks++; if (out_ent[1] !== ent(0, 1'b1, 1'b0, 1, mk_data(0, 61, 0)) || out_cyc[1] !== c0 + 7)
            begin errors++; $display("FAIL rstmid_new_first got=%h@%0d want=%h@%0d", out_ent[1], out_cyc[1], ent(0, 1'b1, 1'b0, 1, mk_data(0, 61, 0)), c0 + 7); end
        checks++; if (out_ent[2] !== ent(0, 1'b0, 1'b1, 1, mk_data(0, 61, 1)))
            begin errors++; $display("FAIL rstmid_new_last got=%h want=%h", out_ent[2], ent(0, 1'b0, 1'b1, 1, mk_data(0, 61, 1))); end
    endtask

    task automatic test_counters();
        logic [31:0] want;
`ifdef PKT_TX_MUX_STATS_EN
        force dut.cnt_q = {exp_cnt[3], exp_cnt[2], exp_cnt[1], 32'hFFFF_FFFF};
        wait_cyc(1);
        release dut.cnt_q;
        exp_cnt[0] = 32'hFFFF_FFFF;
        add_pkt(0, 2, 0, 71);
`endif
        add_pkt(2, 1, 0, 70);
        wait_cyc(10);
        for (int c = 0; c < 4; c++) begin
`ifdef PKT_TX_MUX_STATS_EN
            want = exp_cnt[c];
`else
            want = 32'd0;
`endif
            checks++; if (pkt_cnt[c*32 +: 32] !== want)
                begin errors++; $display("FAIL pkt_cnt ch=%0d got=%h want=%h", c, pkt_cnt[c*32 +: 32], want); end
        end
    endtask

    initial begin
        reset_156m25 = 1'b1;
        pkt_tx_full  = 1'b0;
        in_val       = 4'b0;
        in_sop       = 4'b0;
        in_eop       = 4'b0;
        in_mod       = 12'd0;
        in_data      = 256'd0;
        for (int c = 0; c < 4; c++) begin
            q_len[c]   = 0;
            q_idx[c]   = 0;
            exp_cnt[c] = 32'd0;
        end
        test_reset();
        test_round_robin();
        test_single_pkt();
        test_backpressure();
        test_mid_sop();
        test_stray();
        test_reset_mid();
        test_counters();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
